elevator_call_scheduler: RTL and testbench

- Request-side companion to the 4-floor elevator FSM: latches hall/car call buttons and drives one-hot floor requests into the elevator's ip_ground..ip_third inputs.
- Consumes the elevator's one-hot position outputs (op_ground..op_third) to detect arrival.
- Applies SCAN (keep direction while calls remain ahead), times a door-open hold, and flags a stuck elevator via a travel timeout.

---
 rtl/elevator_call_scheduler.sv | 170 +++++++++++++++++
 tb/tb_elevator_call_scheduler.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/elevator_call_scheduler.sv
// Request-side scheduler for the 4-floor elevator: latches call buttons, picks
// the next floor with SCAN ordering, times the door hold and flags stuck travel.
module elevator_call_scheduler #(
  parameter int DOOR_HOLD      = 8,
  parameter int TRAVEL_TIMEOUT = 64,
  parameter int CNT_W          = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] btn_i,
  input  logic [3:0] pos_i,
  output logic [3:0] req_o,
  output logic [3:0] pending_o,
  output logic       door_open_o,
  output logic [1:0] cur_floor_o,
  output logic       dir_up_o,
  output logic       busy_o,
  output logic       fault_o
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_MOVE  = 2'd1;
  localparam logic [1:0] S_DOOR  = 2'd2;
  localparam logic [1:0] S_FAULT = 2'd3;

  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(DOOR_HOLD - 1);
  localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(TRAVEL_TIMEOUT - 1);

  logic [1:0]       state_q, state_d;
  logic [3:0]       req_q, req_d;
  logic [3:0]       pending_q, pending_d;
  logic             door_q, door_d;
  logic [1:0]       cur_floor_q, cur_floor_d;
  logic             dir_up_q, dir_up_d;
  logic             fault_q, fault_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic       pos_valid;
  logic [1:0] pos_idx;
  logic [3:0] calls_above, calls_below;

  function automatic logic [3:0] lowest_bit(input logic [3:0] v);
    lowest_bit = v & (~v + 4'd1);
  endfunction

  function automatic logic [3:0] highest_bit(input logic [3:0] v);
    highest_bit = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      if (v[i]) highest_bit = 4'b0001 << i;
    end
  endfunction

  // Zero or multi-hot position codes are ignored so the last good floor is kept.
  assign pos_valid = (pos_i != 4'b0000) && ((pos_i & (pos_i - 4'd1)) == 4'b0000);

  always_comb begin
    pos_idx = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (pos_i[i]) pos_idx = 2'(i);
    end
  end

  assign calls_above = pending_q & (4'b1110 << cur_floor_q);
  assign calls_below = pending_q & ~(4'b1111 << cur_floor_q);

  always_comb begin
    // NOTE: every next-state signal gets a default first so no path infers a latch.
    state_d     = state_q;
    req_d       = req_q;
    pending_d   = pending_q | btn_i;
    door_d      = door_q;
    cur_floor_d = pos_valid ? pos_idx : cur_floor_q;
    dir_up_d    = dir_up_q;
    fault_d     = fault_q;
    cnt_d       = cnt_q;

    case (state_q)
      S_IDLE: begin
        if (pending_q[cur_floor_q]) begin
          pending_d[cur_floor_q] = 1'b0;
          door_d  = 1'b1;
          cnt_d   = HOLD_LOAD;
          state_d = S_DOOR;
        end else if (pending_q != 4'b0000) begin
          if (dir_up_q) begin
            if (calls_above != 4'b0000) begin
              req_d = lowest_bit(calls_above);
            end else begin
              req_d    = highest_bit(calls_below);
              dir_up_d = 1'b0;
            end
          end else begin
            if (calls_below != 4'b0000) begin
              req_d = highest_bit(calls_below);
            end else begin
              req_d    = lowest_bit(calls_above);
              dir_up_d = 1'b1;
            end
          end
          cnt_d   = '0;
          state_d = S_MOVE;
        end
      end
      S_MOVE: begin
        if (pos_i == req_q) begin
          pending_d = pending_d & ~req_q;
          req_d     = 4'b0000;
          door_d    = 1'b1;
          cnt_d     = HOLD_LOAD;
          state_d   = S_DOOR;
        end else if (cnt_q == TMO_LAST) begin
          req_d   = 4'b0000;
          fault_d = 1'b1;
          state_d = S_FAULT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DOOR: begin
        // A press at the open floor extends the hold instead of queuing a call.
        pending_d[cur_floor_q] = pending_q[cur_floor_q];
        if (cnt_q == '0) begin
          door_d  = 1'b0;
          state_d = S_IDLE;
        end else if (btn_i[cur_floor_q]) begin
          cnt_d = HOLD_LOAD;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        req_d   = 4'b0000;
        door_d  = 1'b0;
        fault_d = 1'b1;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      req_q       <= 4'b0000;
      pending_q   <= 4'b0000;
      door_q      <= 1'b0;
      cur_floor_q <= 2'd0;
      dir_up_q    <= 1'b1;
      fault_q     <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      pending_q   <= pending_d;
      door_q      <= door_d;
      cur_floor_q <= cur_floor_d;
      dir_up_q    <= dir_up_d;
      fault_q     <= fault_d;
      cnt_q       <= cnt_d;
    end
  end

  assign req_o       = req_q;
  assign pending_o   = pending_q;
  assign door_open_o = door_q;
  assign cur_floor_o = cur_floor_q;
  assign dir_up_o    = dir_up_q;
  assign busy_o      = (state_q != S_IDLE);
  assign fault_o     = fault_q;

endmodule

// File: tb/tb_elevator_call_scheduler.sv
// Directed bench for elevator_call_scheduler: hand-computed expectations for
// reset, single call, SCAN ordering, door restart, invalid position and timeout.
module tb_elevator_call_scheduler;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] btn;
  logic [3:0] pos;
  logic [3:0] req;
  logic [3:0] pending;
  logic       door_open;
  logic [1:0] cur_floor;
  logic       dir_up;
  logic       busy;
  logic       fault;

  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;
  int n;

  always #5 clk = ~clk;

  elevator_call_scheduler #(
    .DOOR_HOLD      (8),
    .TRAVEL_TIMEOUT (64),
    .CNT_W          (8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .btn_i       (btn),
    .pos_i       (pos),
    .req_o       (req),
    .pending_o   (pending),
    .door_open_o (door_open),
    .cur_floor_o (cur_floor),
    .dir_up_o    (dir_up),
    .busy_o      (busy),
    .fault_o     (fault)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Counts consecutive sampled cycles with door_open high, bounded.
  task automatic count_door(output int len);
    len = 0;
    while (door_open === 1'b1 && len < 40) begin
      len++;
      tick();
    end
  endtask

  initial begin
    rst = 1'b1;
    btn = 4'b0000;
    pos = 4'b0001;
    #1;
    check("rst_req",       32'(req),       32'h0);
    check("rst_pending",   32'(pending),   32'h0);
    check("rst_door",      32'(door_open), 32'h0);
    check("rst_cur_floor", 32'(cur_floor), 32'h0);
    check("rst_dir_up",    32'(dir_up),    32'h1);
    check("rst_busy",      32'(busy),      32'h0);
    check("rst_fault",     32'(fault),     32'h0);
    tick();
    tick();
    rst = 1'b0;
    tick();
    check("idle_cur_floor", 32'(cur_floor), 32'h0);

    // Single call to floor 2 from floor 0
    btn = 4'b0100;
    tick();
    check("single_pending", 32'(pending), 32'h4);
    check("single_no_req_yet", 32'(req), 32'h0);
    btn = 4'b0000;
    tick();
    check("single_req", 32'(req), 32'h4);
    check("single_busy", 32'(busy), 32'h1);
    tick();
    tick();
    check("single_req_held", 32'(req), 32'h4);
    pos = 4'b0100;
    tick();
    check("single_arr_req", 32'(req), 32'h0);
    check("single_arr_pending", 32'(pending), 32'h0);
    check("single_arr_floor", 32'(cur_floor), 32'h2);
    count_door(n);
    check("single_door_len", 32'(n), 32'd8);
    check("single_idle", 32'(busy), 32'h0);

    // SCAN: from floor 1 going up with calls at 0, 2, 3
    pos = 4'b0010;
    tick();
    check("scan_cur_floor", 32'(cur_floor), 32'h1);
    btn = 4'b1101;
    tick();
    check("scan_pending", 32'(pending), 32'hd);
    btn = 4'b0000;
    tick();
    check("scan_req1", 32'(req), 32'h4);
    pos = 4'b0100;
    tick();
    check("scan_pending1", 32'(pending), 32'h9);
    count_door(n);
    check("scan_door1", 32'(n), 32'd8);
    tick();
    check("scan_req2", 32'(req), 32'h8);
    check("scan_dir2", 32'(dir_up), 32'h1);
    pos = 4'b1000;
    tick();
    check("scan_pending2", 32'(pending), 32'h1);
    count_door(n);
    check("scan_door2", 32'(n), 32'd8);
    tick();
    check("scan_req3", 32'(req), 32'h1);
    check("scan_dir3", 32'(dir_up), 32'h0);

    // Invalid position codes while travelling down from floor 3
    pos = 4'b0000;
    tick();
    check("inv_zero_floor", 32'(cur_floor), 32'h3);
    check("inv_zero_req", 32'(req), 32'h1);
    pos = 4'b0110;
    tick();
    check("inv_multi_floor", 32'(cur_floor), 32'h3);
    check("inv_multi_req", 32'(req), 32'h1);
    check("inv_multi_door", 32'(door_open), 32'h0);
    pos = 4'b0001;
    tick();
    check("scan_arr3_req", 32'(req), 32'h0);
    check("scan_arr3_pending", 32'(pending), 32'h0);
    check("scan_arr3_floor", 32'(cur_floor), 32'h0);
    count_door(n);
    check("scan_door3", 32'(n), 32'd8);

    // Current-floor call with a door restart on hold cycle 5
    pos = 4'b0100;
    tick();
    check("cur_floor2", 32'(cur_floor), 32'h2);
    btn = 4'b0100;
    tick();
    check("cur_pending", 32'(pending), 32'h4);
    btn = 4'b0000;
    tick();
    check("cur_door", 32'(door_open), 32'h1);
    check("cur_no_req", 32'(req), 32'h0);
    check("cur_pending_clr", 32'(pending), 32'h0);
    n = 0;
    while (door_open === 1'b1 && n < 40) begin
      n++;
      btn = (n == 5) ? 4'b0100 : 4'b0000;
      tick();
      if (n == 5) check("restart_pending", 32'(pending), 32'h0);
    end
    btn = 4'b0000;
    check("restart_door_len", 32'(n), 32'd13);
    check("restart_pending_end", 32'(pending), 32'h0);
    check("restart_idle", 32'(busy), 32'h0);

    // Travel timeout: call floor 3 while the car never leaves floor 0
    pos = 4'b0001;
    tick();
    btn = 4'b1000;
    tick();
    btn = 4'b0000;
    tick();
    check("tmo_req", 32'(req), 32'h8);
    check("tmo_dir", 32'(dir_up), 32'h1);
    repeat (63) tick();
    check("tmo_not_yet_req", 32'(req), 32'h8);
    check("tmo_not_yet_fault", 32'(fault), 32'h0);
    tick();
    check("tmo_req_drop", 32'(req), 32'h0);
    check("tmo_fault", 32'(fault), 32'h1);
    check("tmo_busy", 32'(busy), 32'h1);
    btn = 4'b0010;
    tick();
    btn = 4'b0000;
    check("fault_latch", 32'(pending), 32'ha);
    repeat (3) tick();
    check("fault_sticky", 32'(fault), 32'h1);
    check("fault_no_req", 32'(req), 32'h0);
    check("fault_no_door", 32'(door_open), 32'h0);

    // Reset mid-MOVE
    #2;
    rst = 1'b1;
    #1;
    rst = 1'b0;
    tick();
    btn = 4'b0100;
    tick();
    btn = 4'b1000;
    tick();
    btn = 4'b0000;
    check("mid_req", 32'(req), 32'h4);
    check("mid_pending", 32'(pending), 32'hc);
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_req", 32'(req), 32'h0);
    check("mid_rst_pending", 32'(pending), 32'h0);
    check("mid_rst_fault", 32'(fault), 32'h0);
    check("mid_rst_dir", 32'(dir_up), 32'h1);
    check("mid_rst_busy", 32'(busy), 32'h0);
    tick();
    rst = 1'b0;
    tick();
    check("post_rst_busy", 32'(busy), 32'h0);
    check("post_rst_req", 32'(req), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
